// File: rtl/core_dq_pkg.sv
// -----------------------------------------------------------------------------
// core_dq_pkg
// Shared helpers for the ordered data queue family.
// Ids are PTR_W = $clog2(depth)+1 bits wide: the low bits hold the slot
// index and the msb holds a wrap flag. That makes two ids age-comparable
// even when depth is not a power of two. The helpers take ids
// zero-extended to 32 bits plus the queue depth, so any instance width
// can use them.
//   count_one   : popcount of a 32-bit vector
//   ptr_add     : id + n with wrap at depth (the flag toggles on wrap)
//   ptr_dist    : number of steps from id b forward to id a
//   ptr_younger : 1 when id a was allocated after id b
//   in_squash   : 1 when slot idx lies in [sq+1, tail)
// -----------------------------------------------------------------------------
package core_dq_pkg;

    function automatic int unsigned count_one(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (v[b]) n++;
        end
        return n;
    endfunction

    function automatic int unsigned ptr_iw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned ptr_idx(input logic [31:0] p, input int unsigned depth);
        return p & ((32'd1 << ptr_iw(depth)) - 32'd1);
    endfunction

    function automatic logic ptr_flag(input logic [31:0] p, input int unsigned depth);
        return p[ptr_iw(depth)];
    endfunction

    // n never exceeds depth, so a single wrap correction is enough.
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr, input int unsigned n,
                                            input int unsigned depth);
        int unsigned idx;
        logic        flag;
        logic [31:0] r;
        idx  = ptr_idx(ptr, depth) + n;
        flag = ptr_flag(ptr, depth);
        if (idx >= depth) begin
            idx  = idx - depth;
            flag = ~flag;
        end
        r = idx;
        r[ptr_iw(depth)] = flag;
        return r;
    endfunction

    function automatic int unsigned ptr_dist(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned depth);
        if (ptr_flag(a, depth) == ptr_flag(b, depth))
            return ptr_idx(a, depth) - ptr_idx(b, depth);
        return ptr_idx(a, depth) + depth - ptr_idx(b, depth);
    endfunction

    function automatic logic ptr_younger(input logic [31:0] a, input logic [31:0] b,
                                         input int unsigned depth);
        if (ptr_flag(a, depth) == ptr_flag(b, depth))
            return ptr_idx(a, depth) > ptr_idx(b, depth);
        return ptr_idx(a, depth) < ptr_idx(b, depth);
    endfunction

    function automatic logic in_squash(input int unsigned idx, input logic [31:0] sq,
                                       input logic [31:0] tail, input int unsigned depth);
        int unsigned sq_idx;
        int unsigned off;
        sq_idx = ptr_idx(sq, depth);
        off    = (idx >= sq_idx) ? idx - sq_idx : idx + depth - sq_idx;
        return (off >= 1) && (off < ptr_dist(tail, sq, depth));
    endfunction

endpackage

// File: rtl/dq_ptr_gen.sv
// -----------------------------------------------------------------------------
// dq_ptr_gen
// Produces NUM consecutive wrapped ids, base_i + 0 .. base_i + NUM-1.
//   base_i : starting id (PTR_W bits, msb = wrap flag)
//   ids_o  : NUM consecutive ids
// -----------------------------------------------------------------------------
module dq_ptr_gen
    import core_dq_pkg::*;
#(
    parameter int unsigned PTR_W = 6,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NUM   = 4
) (
    input  logic [PTR_W-1:0] base_i,
    output logic [PTR_W-1:0] ids_o [NUM]
);

    always_comb begin
        for (int unsigned k = 0; k < NUM; k++) begin
            ids_o[k] = PTR_W'(ptr_add(32'(base_i), k, DEPTH));
        end
    end

endmodule

// File: rtl/ordered_data_que.sv
// -----------------------------------------------------------------------------
// ordered_data_que
// Circular in-order allocate / out-of-order done / in-order retire queue.
// It serves as the imm buffer, the branch buffer and the ROB payload store.
//   clk, rst                 : clock and asynchronous active-high reset
//   o_can_enq                : every requested lane fits in the free space
//   i_enq_vld / i_enq_req    : enqueue strobe and sparse per-lane request
//   i_enq_data, o_alloc_id   : lane payloads and the ids allocated to them
//   i_read_id, o_read_data,
//   o_read_wb                : combinational random reads
//   i_clear_vld, i_clear_id  : mark-done ports
//   i_wb_vld/id/data         : writeback side-array ports (when HAS_WB)
//   i_squash_vld/id          : drop every entry younger than i_squash_id
//   i_flush                  : drop everything
//   o_retire_*               : up to COMMIT_WID in-order retirements
//   o_count                  : registered occupancy
// -----------------------------------------------------------------------------
module ordered_data_que
    import core_dq_pkg::*;
#(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned INPORT_NUM    = 4,
    parameter int unsigned READPORT_NUM  = 4,
    parameter int unsigned CLEARPORT_NUM = 4,
    parameter int unsigned WBPORT_NUM    = 2,
    parameter int unsigned COMMIT_WID    = 4,
    parameter type         dtype         = logic [63:0],
    parameter type         wbtype        = logic [63:0],
    parameter bit          HAS_WB        = 1'b0,
    localparam int unsigned PTR_W        = $clog2(DEPTH) + 1,
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     o_can_enq,
    input  logic                     i_enq_vld,
    input  logic [INPORT_NUM-1:0]    i_enq_req,
    input  dtype                     i_enq_data    [INPORT_NUM],
    output logic [PTR_W-1:0]         o_alloc_id    [INPORT_NUM],
    input  logic [PTR_W-1:0]         i_read_id     [READPORT_NUM],
    output dtype                     o_read_data   [READPORT_NUM],
    output wbtype                    o_read_wb     [READPORT_NUM],
    input  logic [CLEARPORT_NUM-1:0] i_clear_vld,
    input  logic [PTR_W-1:0]         i_clear_id    [CLEARPORT_NUM],
    input  logic [WBPORT_NUM-1:0]    i_wb_vld,
    input  logic [PTR_W-1:0]         i_wb_id       [WBPORT_NUM],
    input  wbtype                    i_wb_data     [WBPORT_NUM],
    input  logic                     i_squash_vld,
    input  logic [PTR_W-1:0]         i_squash_id,
    input  logic                     i_flush,
    output logic [COMMIT_WID-1:0]    o_retire_vld,
    output logic [PTR_W-1:0]         o_retire_id   [COMMIT_WID],
    output dtype                     o_retire_data [COMMIT_WID],
    output wbtype                    o_retire_wb   [COMMIT_WID],
    output logic [CNT_W-1:0]         o_count
);

    localparam int unsigned IW = PTR_W - 1;

    function automatic logic [IW-1:0] slot(input logic [PTR_W-1:0] id);
        return id[IW-1:0];
    endfunction

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d, done_q, done_d;
    dtype             mem_q [DEPTH];

    logic [PTR_W-1:0] alloc_ids  [INPORT_NUM];
    logic [PTR_W-1:0] retire_ids [COMMIT_WID];
    int unsigned      enq_cnt, ret_cnt;
    logic             do_enq;

    dq_ptr_gen #(.PTR_W(PTR_W), .DEPTH(DEPTH), .NUM(INPORT_NUM)) u_alloc_gen (
        .base_i (tail_q),
        .ids_o  (alloc_ids)
    );

    dq_ptr_gen #(.PTR_W(PTR_W), .DEPTH(DEPTH), .NUM(COMMIT_WID)) u_retire_gen (
        .base_i (head_q),
        .ids_o  (retire_ids)
    );

    assign enq_cnt   = count_one(32'(i_enq_req));
    assign o_can_enq = enq_cnt <= (DEPTH - 32'(count_q));
    assign do_enq    = i_enq_vld & o_can_enq & ~i_squash_vld & ~i_flush;
    assign o_count   = count_q;

    // Lane k takes the id offset by the number of requesting lanes below it.
    // The inner match loop keeps every array index constant.
    always_comb begin
        int unsigned pre;
        pre = 0;
        for (int unsigned k = 0; k < INPORT_NUM; k++) begin
            o_alloc_id[k] = alloc_ids[0];
            for (int unsigned m = 0; m < INPORT_NUM; m++) begin
                if (m == pre) o_alloc_id[k] = alloc_ids[m];
            end
            if (i_enq_req[k]) pre++;
        end
    end

    // Retire lanes form a contiguous run of done entries from head. The
    // occupancy guard stops a lane from aliasing a slot when DEPTH is
    // smaller than COMMIT_WID.
    always_comb begin
        logic          chain;
        logic [IW-1:0] rs;
        chain = 1'b1;
        for (int unsigned j = 0; j < COMMIT_WID; j++) begin
            rs               = slot(retire_ids[j]);
            chain            = chain & vld_q[rs] & done_q[rs] & (j < 32'(count_q));
            o_retire_vld[j]  = chain;
            o_retire_id[j]   = retire_ids[j];
            o_retire_data[j] = mem_q[rs];
        end
    end

    assign ret_cnt = count_one(32'(o_retire_vld));

    always_comb begin
        for (int unsigned r = 0; r < READPORT_NUM; r++) begin
            o_read_data[r] = mem_q[slot(i_read_id[r])];
        end
    end

    // The updates are applied in a fixed order, and later ones override
    // earlier ones: enqueue, clear, squash, retire, then flush.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        done_d = done_q;
        if (do_enq) begin
            for (int unsigned k = 0; k < INPORT_NUM; k++) begin
                if (i_enq_req[k]) begin
                    vld_d[slot(o_alloc_id[k])]  = 1'b1;
                    done_d[slot(o_alloc_id[k])] = 1'b0;
                end
            end
            tail_d = PTR_W'(ptr_add(32'(tail_q), enq_cnt, DEPTH));
        end
        for (int unsigned c = 0; c < CLEARPORT_NUM; c++) begin
            if (i_clear_vld[c]) done_d[slot(i_clear_id[c])] = 1'b1;
        end
        if (i_squash_vld) begin
            tail_d = PTR_W'(ptr_add(32'(i_squash_id), 1, DEPTH));
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (in_squash(i, 32'(i_squash_id), 32'(tail_q), DEPTH)) begin
                    vld_d[i]  = 1'b0;
                    done_d[i] = 1'b0;
                end
            end
        end
        for (int unsigned j = 0; j < COMMIT_WID; j++) begin
            if (o_retire_vld[j]) begin
                vld_d[slot(retire_ids[j])]  = 1'b0;
                done_d[slot(retire_ids[j])] = 1'b0;
            end
        end
        head_d = PTR_W'(ptr_add(32'(head_q), ret_cnt, DEPTH));
        if (i_flush) begin
            head_d = '0;
            tail_d = '0;
            vld_d  = '0;
            done_d = '0;
        end
        count_d = CNT_W'(ptr_dist(32'(tail_d), 32'(head_d), DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    // The payload array is not reset.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int unsigned k = 0; k < INPORT_NUM; k++) begin
                if (i_enq_req[k]) mem_q[slot(o_alloc_id[k])] <= i_enq_data[k];
            end
        end
    end

    if (HAS_WB) begin : g_wb
        wbtype wb_q [DEPTH];

        // Ports are scanned in ascending order, so the highest port wins.
        always_ff @(posedge clk) begin
            if (!i_flush) begin
                for (int unsigned p = 0; p < WBPORT_NUM; p++) begin
                    if (i_wb_vld[p] && !(i_squash_vld &&
                        in_squash(32'(slot(i_wb_id[p])), 32'(i_squash_id), 32'(tail_q), DEPTH)))
                        wb_q[slot(i_wb_id[p])] <= i_wb_data[p];
                end
            end
        end

        always_comb begin
            for (int unsigned r = 0; r < READPORT_NUM; r++) o_read_wb[r] = wb_q[slot(i_read_id[r])];
            for (int unsigned j = 0; j < COMMIT_WID; j++) o_retire_wb[j] = wb_q[slot(retire_ids[j])];
        end
    end else begin : g_no_wb
        logic wb_unused;
        always_comb begin
            wb_unused = ^i_wb_vld;
            for (int unsigned p = 0; p < WBPORT_NUM; p++) wb_unused = wb_unused ^ (^i_wb_data[p]);
            for (int unsigned r = 0; r < READPORT_NUM; r++) o_read_wb[r] = '0;
            for (int unsigned j = 0; j < COMMIT_WID; j++) o_retire_wb[j] = '0;
        end
    end

    // Reads, clears and writebacks address a slot directly. Their wrap flags are not needed.
    logic flag_unused;
    always_comb begin
        flag_unused = 1'b0;
        for (int unsigned r = 0; r < READPORT_NUM; r++) flag_unused = flag_unused ^ i_read_id[r][IW];
        for (int unsigned c = 0; c < CLEARPORT_NUM; c++) flag_unused = flag_unused ^ i_clear_id[c][IW];
        for (int unsigned p = 0; p < WBPORT_NUM; p++) flag_unused = flag_unused ^ i_wb_id[p][IW];
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            for (int unsigned c = 0; c < CLEARPORT_NUM; c++) begin
                if (i_clear_vld[c]) assert (vld_q[slot(i_clear_id[c])]);
            end
            for (int unsigned p = 0; p < WBPORT_NUM; p++) begin
                if (i_wb_vld[p]) assert (vld_q[slot(i_wb_id[p])]);
            end
            if (i_squash_vld)
                assert (vld_q[slot(i_squash_id)] &&
                        !ptr_younger(32'(head_q), 32'(i_squash_id), DEPTH));
        end
    end

endmodule
